sw_ctrl: RTL

Front-panel controller for the stopwatch counter chain. It debounces two raw push-buttons and runs a mode state machine (idle/run/lap/pause). It turns key presses into the `start_stop` and `clear` pulses the stopwatch consumes, freezes a lap snapshot on request, and time-multiplexes the six BCD digits onto a single-digit scan output for the 7-segment driver.

---
 rtl/sw_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/sw_ctrl.sv
// sw_ctrl: stopwatch front-panel controller.
// Debounces the start/stop and lap keys and classifies lap presses as short
// or long. A mode FSM (idle/run/lap/pause) turns key events into 2-cycle
// start_stop/clear pulses and keeps a lap snapshot. The six BCD digits are
// scanned onto a single digit output.
module sw_ctrl #(
  parameter int unsigned DEBOUNCE_CYC = 20,
  parameter int unsigned LONG_CYC     = 100,
  parameter int unsigned SCAN_CYC     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_ss,
  input  logic        key_lap,
  input  logic [23:0] time_in,
  output logic        start_stop,
  output logic        clear,
  output logic        running,
  output logic        lap_active,
  output logic [5:0]  dig_sel,
  output logic [3:0]  dig_val
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 2);
  localparam int unsigned SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LAP, S_PAUSE} state_t;

  // Index 0 = start/stop key, index 1 = lap key.
  logic [1:0]        keys;
  logic [1:0]        sync1_q, sync2_q, deb_q, deb_prev_q;
  logic [DB_W-1:0]   db_cnt_q [2];
  logic [HOLD_W-1:0] hold_q;

  logic   ss_press, lap_long, lap_short;

  state_t      state_q;
  logic        ss_q, ss_hold_q, clr_q, clr_hold_q;
  logic        running_q, lap_q;
  logic [23:0] snap_q;

  logic [SCAN_W-1:0] scan_cnt_q;
  logic              scan_wrap;
  logic [5:0]        sel_q, sel_d;
  logic [3:0]        val_q, val_d;
  logic [23:0]       disp_src;

  assign keys = {key_lap, key_ss};

  // Two-flop synchronizers followed by per-key stability counters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int unsigned k = 0; k < 2; k++) db_cnt_q[k] <= '0;
    end else begin
      sync1_q    <= keys;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int unsigned k = 0; k < 2; k++) begin
        if (sync2_q[k] == deb_q[k]) begin
          db_cnt_q[k] <= '0;
        end else if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb_q[k]    <= sync2_q[k];
          db_cnt_q[k] <= '0;
        end else begin
          db_cnt_q[k] <= db_cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Lap hold counter; saturates one past LONG_CYC so the long event fires once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_q <= '0;
    end else if (!deb_q[1]) begin
      hold_q <= '0;
    end else if (hold_q != HOLD_W'(LONG_CYC + 1)) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  // Key event strobes; a release after a long press sees the saturated count.
  always_comb begin
    ss_press  = deb_q[0] & ~deb_prev_q[0];
    lap_long  = deb_q[1] && (hold_q == HOLD_W'(LONG_CYC));
    lap_short = ~deb_q[1] && deb_prev_q[1] && (hold_q <= HOLD_W'(LONG_CYC));
  end

  // Mode FSM with registered pulses, status flags and lap snapshot.
  // A long press also cuts a start_stop pulse in flight, and a start/stop
  // press during a clear pulse is dropped, so the two pulses never overlap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      ss_q       <= 1'b0;
      ss_hold_q  <= 1'b0;
      clr_q      <= 1'b0;
      clr_hold_q <= 1'b0;
      running_q  <= 1'b0;
      lap_q      <= 1'b0;
      snap_q     <= '0;
    end else begin
      ss_q       <= ss_hold_q;
      ss_hold_q  <= 1'b0;
      clr_q      <= clr_hold_q;
      clr_hold_q <= 1'b0;
      if (lap_long) begin
        state_q    <= S_IDLE;
        running_q  <= 1'b0;
        lap_q      <= 1'b0;
        clr_q      <= 1'b1;
        clr_hold_q <= 1'b1;
        ss_q       <= 1'b0;
        ss_hold_q  <= 1'b0;
      end else if (ss_press && !clr_q) begin
        ss_q      <= 1'b1;
        ss_hold_q <= 1'b1;
        lap_q     <= 1'b0;
        case (state_q)
          S_IDLE, S_PAUSE: begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
          default: begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end
        endcase
      end else if (lap_short) begin
        case (state_q)
          S_RUN: begin
            state_q <= S_LAP;
            lap_q   <= 1'b1;
            snap_q  <= time_in;
          end
          S_LAP: begin
            state_q <= S_RUN;
            lap_q   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  // Next digit select and its value from the current display source.
  always_comb begin
    scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_CYC - 1));
    sel_d     = scan_wrap ? {sel_q[4:0], sel_q[5]} : sel_q;
    disp_src  = (state_q == S_LAP) ? snap_q : time_in;
    val_d     = '0;
    for (int unsigned i = 0; i < 6; i++) begin
      if (sel_d[i]) val_d = disp_src[4*i +: 4];
    end
  end

  // Free-running digit scanner.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scan_cnt_q <= '0;
      sel_q      <= 6'b000001;
      val_q      <= '0;
    end else begin
      scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
      sel_q      <= sel_d;
      val_q      <= val_d;
    end
  end

  assign start_stop = ss_q;
  assign clear      = clr_q;
  assign running    = running_q;
  assign lap_active = lap_q;
  assign dig_sel    = sel_q;
  assign dig_val    = val_q;

endmodule
